ars_bk_round_ctrl: RTL and testbench

ARS_BK_ROUND_CTRL -- requirements
Module: ars_bk_round_ctrl

---
 rtl/ars_bk_round_ctrl.sv | 121 ++++++++++++
 tb/tb_ars_bk_round_ctrl.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ars_bk_round_ctrl.sv
// Round controller for a 32-round, four-word shifting block transform.
// The four state words are exposed so that an external round function
// can compute X(i+4). That word comes back on f_in and is shifted in at
// each RUN edge. After 32 rounds the block is presented in reversed word
// order and held until downstream accepts it.
module ars_bk_round_ctrl #(
    parameter int BWIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [0:4*BWIDTH-1]   din,
    input  logic [0:BWIDTH-1]     f_in,
    output logic [0:BWIDTH-1]     x0_out,
    output logic [0:BWIDTH-1]     x1_out,
    output logic [0:BWIDTH-1]     x2_out,
    output logic [0:BWIDTH-1]     x3_out,
    output logic [4:0]            rnd_idx,
    output logic                  busy,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [0:4*BWIDTH-1]   dout
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [0:BWIDTH-1] x_q [0:3];
    logic [0:BWIDTH-1] x_d [0:3];
    logic [4:0]        rnd_q;
    logic [4:0]        rnd_d;
    logic              last_round;

    assign last_round = (rnd_q == 5'd31);

    // State register; reset takes effect immediately, without a clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode. start only matters in IDLE and out_ready only in DONE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start)      state_d = S_RUN;
            S_RUN:   if (last_round) state_d = S_DONE;
            S_DONE:  if (out_ready)  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode. dout is gated so that it reads zero whenever no result is offered.
    always_comb begin
        busy      = (state_q != S_IDLE);
        out_valid = (state_q == S_DONE);
        dout      = '0;
        if (state_q == S_DONE) begin
            dout = {x_q[3], x_q[2], x_q[1], x_q[0]};
        end
    end

    // Datapath next values: load on start, shift in f_in while running, hold otherwise.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            x_d[k] = x_q[k];
        end
        rnd_d = rnd_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    for (int k = 0; k < 4; k++) begin
                        x_d[k] = din[k*BWIDTH +: BWIDTH];
                    end
                    rnd_d = 5'd0;
                end
            end
            S_RUN: begin
                x_d[0] = x_q[1];
                x_d[1] = x_q[2];
                x_d[2] = x_q[3];
                x_d[3] = f_in;
                rnd_d  = last_round ? 5'd0 : (rnd_q + 5'd1);
            end
            default: begin
                // DONE holds the finished block; f_in is not looked at.
            end
        endcase
    end

    // Datapath registers; every output below comes straight from these flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 4; k++) begin
                x_q[k] <= '0;
            end
            rnd_q <= 5'd0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                x_q[k] <= x_d[k];
            end
            rnd_q <= rnd_d;
        end
    end

    assign x0_out  = x_q[0];
    assign x1_out  = x_q[1];
    assign x2_out  = x_q[2];
    assign x3_out  = x_q[3];
    assign rnd_idx = rnd_q;

endmodule

// File: tb/tb_ars_bk_round_ctrl.sv
// Testbench for ars_bk_round_ctrl. The bench provides the round function:
// either identity (X(i+4) = X(i)) or SM4. The driver pushes the expected
// block and the start-sample cycle into a scoreboard. A negedge monitor
// checks round index, latency and dout against that scoreboard.
module tb_ars_bk_round_ctrl;

    logic           clk;
    logic           rst;
    logic           start;
    logic [0:127]   din;
    logic [0:31]    f_in;
    logic [0:31]    x0_out, x1_out, x2_out, x3_out;
    logic [4:0]     rnd_idx;
    logic           busy;
    logic           out_valid;
    logic           out_ready;
    logic [0:127]   dout;

    ars_bk_round_ctrl #(.BWIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .din       (din),
        .f_in      (f_in),
        .x0_out    (x0_out),
        .x1_out    (x1_out),
        .x2_out    (x2_out),
        .x3_out    (x3_out),
        .rnd_idx   (rnd_idx),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dout      (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;
    int n_blk = 0;

    typedef struct {
        logic [127:0] dout;
        int           s;
    } exp_t;
    exp_t sb[$];

    localparam logic [127:0] ID_IN   = 128'h00112233_44556677_8899aabb_ccddeeff;
    localparam logic [127:0] ID_OUT  = 128'hccddeeff_8899aabb_44556677_00112233;
    localparam logic [127:0] SM4_KEY = 128'h0123456789abcdeffedcba9876543210;
    localparam logic [127:0] SM4_IN  = 128'h0123456789abcdeffedcba9876543210;
    localparam logic [127:0] SM4_OUT = 128'h681edf34d206965e86b3e94f536e4246;

    // ---------------- SM4 reference round function ----------------
    logic [0:2047] sbox_bits;
    logic [31:0]   rk [0:31];
    logic          mode;   // 0 = identity round function, 1 = SM4

    function automatic logic [7:0] sb_lu(input logic [7:0] a);
        return sbox_bits[8*a +: 8];
    endfunction

    function automatic logic [31:0] rol(input logic [31:0] v, input int n);
        return (v << n) | (v >> (32 - n));
    endfunction

    function automatic logic [31:0] tau(input logic [31:0] b);
        return {sb_lu(b[31:24]), sb_lu(b[23:16]), sb_lu(b[15:8]), sb_lu(b[7:0])};
    endfunction

    function automatic logic [31:0] t_enc(input logic [31:0] a);
        logic [31:0] b;
        b = tau(a);
        return b ^ rol(b, 2) ^ rol(b, 10) ^ rol(b, 18) ^ rol(b, 24);
    endfunction

    function automatic logic [31:0] t_key(input logic [31:0] a);
        logic [31:0] b;
        b = tau(a);
        return b ^ rol(b, 13) ^ rol(b, 23);
    endfunction

    assign f_in = mode ? (x0_out ^ t_enc(x1_out ^ x2_out ^ x3_out ^ rk[rnd_idx])) : x0_out;

    task automatic build_sm4;
        logic [31:0] k [0:35];
        logic [31:0] fk [0:3];
        logic [31:0] ck;
        sbox_bits = {
            128'hd690e9fecce13db716b614c228fb2c05, 128'h2b679a762abe04c3aa44132649860699,
            128'h9c4250f491ef987a33540b43edcfac62, 128'he4b31ca9c908e89580df94fa758f3fa6,
            128'h4707a7fcf37317ba83593c19e6854fa8, 128'h686b81b27164da8bf8eb0f4b70569d35,
            128'h1e240e5e6358d1a225227c3b01217887, 128'hd40046579fd327524c3602e7a0c4c89e,
            128'heabf8ad240c738b5a3f7f2cef96115a1, 128'he0ae5da49b341a55ad933230f58cb1e3,
            128'h1df6e22e8266ca60c02923ab0d534e6f, 128'hd5db3745defd8e2f03ff6a726d6c5b51,
            128'h8d1baf92bbddbc7f11d95c411f105ad8, 128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
            128'h8969974a0c96777e65b9f109c56ec684, 128'h18f07dec3adc4d2079ee5f3ed7cb3948};
        fk[0] = 32'ha3b1bac6; fk[1] = 32'h56aa3350; fk[2] = 32'h677d9197; fk[3] = 32'hb27022dc;
        for (int i = 0; i < 4; i++) k[i] = SM4_KEY[127-32*i -: 32] ^ fk[i];
        for (int i = 0; i < 32; i++) begin
            for (int j = 0; j < 4; j++) ck[31-8*j -: 8] = 8'(((4*i + j) * 7) % 256);
            k[i+4] = k[i] ^ t_key(k[i+1] ^ k[i+2] ^ k[i+3] ^ ck);
            rk[i]  = k[i+4];
        end
    endtask

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_x0"}, x0_out, 0);
        chk({tag, "_x1"}, x1_out, 0);
        chk({tag, "_x2"}, x2_out, 0);
        chk({tag, "_x3"}, x3_out, 0);
        chk({tag, "_rnd"}, rnd_idx, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_valid"}, out_valid, 0);
        chk({tag, "_dout"}, dout, 0);
    endtask

    // ---------------- monitor ----------------
    logic prev_valid = 1'b0;

    // Compare on each negedge so that outputs have settled after the rising edge.
    always @(negedge clk) begin
        if (rst) begin
            prev_valid = 1'b0;
        end else begin
            if (!out_valid) chk("dout_zero_when_invalid", dout, 0);
            if (busy && !out_valid) begin
                if (sb.size() == 0) chk("busy_without_block", busy, 0);
                else chk("rnd_idx", rnd_idx, cyc - sb[0].s);
            end
            if (out_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_valid", out_valid, 0);
                end else begin
                    if (!prev_valid) chk("latency", cyc - sb[0].s, 32);
                    chk("dout", dout, sb[0].dout);
                    chk("busy_in_done", busy, 1);
                    chk("rnd_idx_done", rnd_idx, 0);
                    if (out_ready) begin
                        n_blk++;
                        $display("block %0d: dout=%h accepted at cycle %0d", n_blk, dout, cyc);
                        void'(sb.pop_front());
                    end
                end
            end
            prev_valid = out_valid;
        end
    end

    // ---------------- driver tasks (inputs change at posedge+2) ----------------
    task automatic issue(input logic [127:0] d, input logic [127:0] e);
        exp_t t;
        din   = d;
        start = 1'b1;
        @(posedge clk);
        #1;
        t.dout = e;
        t.s    = cyc;
        sb.push_back(t);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 80) begin @(posedge clk); #2; n++; end
        chk({name, "_idle"}, busy, 0);
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!out_valid && n < 80) begin @(posedge clk); #2; n++; end
        chk({name, "_valid"}, out_valid, 1);
    endtask

    task automatic wait_round(input logic [4:0] r);
        int n = 0;
        while (!(busy && !out_valid && rnd_idx == r) && n < 80) begin @(posedge clk); #2; n++; end
        chk("reach_round", rnd_idx, r);
    endtask

    // ---------------- stimulus ----------------
    logic [127:0] held;

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        din       = '0;
        out_ready = 1'b1;
        mode      = 1'b0;
        build_sm4();
        #2;
        chk_all_zero("reset");

        // Start honoured on the first edge after reset release; identity round.
        @(posedge clk); #2;
        rst = 1'b0;
        issue(ID_IN, ID_OUT);
        wait_idle("identity");

        // SM4 round function.
        mode = 1'b1;
        issue(SM4_IN, SM4_OUT);
        wait_idle("sm4");
        mode = 1'b0;

        // Downstream stall for 10 cycles in DONE.
        out_ready = 1'b0;
        issue(ID_IN, ID_OUT);
        wait_valid("stall");
        held = dout;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #2;
            chk("stall_valid", out_valid, 1);
            chk("stall_dout", dout, held);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("release_valid", out_valid, 0);
        chk("release_busy", busy, 0);
        #1;

        // Reset mid-run at round 17 aborts the block asynchronously.
        issue(ID_IN, ID_OUT);
        wait_round(5'd17);
        rst = 1'b1;
        #1;
        chk_all_zero("abort");
        sb.delete();
        @(posedge clk); #2;
        rst = 1'b0;
        mode = 1'b1;
        issue(SM4_IN, SM4_OUT);
        wait_idle("after_abort");
        mode = 1'b0;

        // start pulses at round 5 and in the handshake cycle are ignored.
        issue(ID_IN, ID_OUT);
        wait_round(5'd5);
        start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        wait_valid("ignore");
        start = 1'b1;
        @(posedge clk); #1;
        chk("handshake_start_busy", busy, 0);
        chk("handshake_start_valid", out_valid, 0);
        #1;

        // Back-to-back: start in the first IDLE cycle after the handshake.
        mode = 1'b1;
        issue(SM4_IN, SM4_OUT);
        wait_idle("back_to_back");
        mode = 1'b0;

        @(posedge clk); #2;
        chk("scoreboard_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
